// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: divide op encodings, divider FSM states,
// datapath width and the ALU control codes that select the divide ops.
package rv32im_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_ctrl_e;

    // Maps a divide-class ALU control code onto the divider op field.
    function automatic div_op_e alu_to_div_op(input alu_ctrl_e ctrl);
        case (ctrl)
            ALU_DIVU: return DIV_OP_DIVU;
            ALU_REM:  return DIV_OP_REM;
            ALU_REMU: return DIV_OP_REMU;
            default:  return DIV_OP_DIV;
        endcase
    endfunction

    function automatic logic is_div_op(input alu_ctrl_e ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU) ||
               (ctrl == ALU_REM) || (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor and record the quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] q_next
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    // The shifted remainder can exceed XLEN bits, so compare via an XLEN+1 borrow.
    always_comb begin
        rem_shift = {rem, q[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            q_next   = {q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[XLEN-1:0];
            q_next   = {q[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: sign-magnitude restoring divider,
// one quotient bit per cycle, with divide-by-zero and overflow shortcuts.
module div_unit
    import rv32im_pkg::*;
#(
    parameter int XLEN = rv32im_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(ITER);

    function automatic logic [XLEN-1:0] neg_val(input logic signed [XLEN-1:0] x);
        return -x;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] x);
        return (x < 0) ? -x : x;
    endfunction

    div_state_e        state_q, state_d;
    div_op_e           op_q, op_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              op_signed;
    logic              op_rem;
    logic              b_zero;
    logic              ovf;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   final_val;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .q_next   (quo_next)
    );

    assign accept    = start && !flush && (state_q == DIV_IDLE || state_q == DIV_DONE);
    assign op_signed = !op[0];
    assign op_rem    = op[1];
    assign b_zero    = (operand_b == '0);
    assign ovf       = op_signed && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (operand_b == '1);

    // Sign correction applied to the last iteration's outputs.
    always_comb begin
        case (op_q)
            DIV_OP_DIV:  final_val = qsign_q ? neg_val(quo_next) : quo_next;
            DIV_OP_DIVU: final_val = quo_next;
            DIV_OP_REM:  final_val = rsign_q ? neg_val(rem_next) : rem_next;
            default:     final_val = rem_next;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (accept) begin
                    op_d      = div_op_e'(op);
                    qsign_d   = operand_a[XLEN-1] ^ operand_b[XLEN-1];
                    rsign_d   = operand_a[XLEN-1];
                    rem_d     = '0;
                    quo_d     = op_signed ? abs_val(operand_a) : operand_a;
                    divisor_d = op_signed ? abs_val(operand_b) : operand_b;
                    count_d   = '0;
                    if (b_zero) begin
                        result_d = op_rem ? operand_a : '1;
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                    end else if (ovf) begin
                        result_d = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d   = rem_next;
                    quo_d   = quo_next;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(ITER-1)) begin
                        result_d = final_val;
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            op_q      <= DIV_OP_DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    // Combinational so the issuing instruction stalls in its own cycle.
    assign busy   = (state_q == DIV_CALC) || accept;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M cases plus randomized ops,
// checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (a),
        .operand_b (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          e0;
        int          edges;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Edges counts how many clock edges after the accepting edge done rises.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output int edges);
        logic [31:0] q;
        logic [31:0] rm;
        int sx;
        int sy;
        sx    = $signed(x);
        sy    = $signed(y);
        edges = 32;
        if (y == 32'h0) begin
            q = 32'hFFFF_FFFF; rm = x; edges = 0;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; rm = 32'h0; edges = 0;
        end else if (!o[0]) begin
            q = sx / sy; rm = sx % sy;
        end else begin
            q = x / y; rm = x % y;
        end
        r = o[1] ? rm : q;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual done=1 result=%h required no pending op", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " result"}, result, e.res);
                check({e.name, " latency"}, cyc - e.e0, e.edges);
            end
        end
    end

    // Must be called right after a falling edge; returns at the falling edge where done is seen.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        exp_t e;
        int   n;
        ref_model(o, x, y, e.res, e.edges);
        e.name   = name;
        e.e0     = cyc + 1;
        last_exp = e.res;
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(e);
        #1 check({name, " busy_at_start"}, busy, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: actual no done required done", name);
                sb.delete();
                break;
            end
        end
        if (done) check({name, " busy_in_done"}, busy, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset result", result, 32'h0);
        check("reset done", done, 1'b0);
        check("reset busy", busy, 1'b0);
        @(negedge clk);

        issue(2'b01, 32'd100, 32'd7, "DIVU 100/7");              idle(1);
        issue(2'b11, 32'd100, 32'd7, "REMU 100/7");              idle(1);
        issue(2'b00, -32'sd100, 32'd7, "DIV -100/7");            idle(1);
        issue(2'b10, -32'sd100, 32'd7, "REM -100/7");            idle(1);
        issue(2'b10, 32'd100, -32'sd7, "REM 100/-7");            idle(1);
        issue(2'b01, 32'd5, 32'd0, "DIVU 5/0");                  idle(1);
        issue(2'b11, 32'd5, 32'd0, "REMU 5/0");                  idle(1);
        issue(2'b00, -32'sd5, 32'd0, "DIV -5/0");                idle(1);
        issue(2'b10, -32'sd5, 32'd0, "REM -5/0");                idle(1);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");   idle(1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");   idle(1);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "DIVU big");  idle(1);

        issue(2'b01, 32'd9, 32'd2, "DIVU 9/2");
        issue(2'b11, 32'd9, 32'd2, "REMU 9/2 b2b");
        idle(1);

        // Flush ten cycles into an iteration.
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", busy, 1'b0);
        check("flush done", done, 1'b0);
        check("flush result held", result, last_exp);
        idle(40);

        // Start together with flush is ignored.
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
        #1 check("start+flush busy", busy, 1'b0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("start+flush not busy after", busy, 1'b0);
        check("start+flush no done", done, 1'b0);
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'd3, "DIVU FFFFFFFF/3");
        idle(2);

        // Reset in the middle of an iteration.
        start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd17;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid result", result, 32'h0);
        check("rst mid done", done, 1'b0);
        check("rst mid busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            int sel;
            sel = $urandom_range(0, 7);
            x = $urandom;
            y = $urandom;
            case (sel)
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                3: x = 32'h8000_0000;
                4: y = y >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(2'($urandom), x, y, $sformatf("rand%0d", i));
            idle($urandom_range(0, 2));
        end

        idle(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
